calc_display_rx: RTL and testbench
==================================

Name: calc_display_rx

Overview:
- Receiver for the calculator's serialized display stream: `status[1:0]`, `data[3:0]` (BCD digit), `pos[3:0]` (digit index).
- Assembles digits into a shadow frame and commits whole frames atomically.
- Drives a time-multiplexed 8-digit common-anode 7-segment display (board top level) with leading-zero blanking and an "Erro" screen.
- Sits between the calculator core and the board display pins.

Parameters:
- NUM_DIGITS, 8, number of display digits; also the frame length; index 0 = least significant.
- REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range 2..2^20.
- SEG_ACTIVE_LOW, 1, 1 = segments/anodes active-low, 0 = active-high.

Ports:
- clock  input  1  system clock
- reset  input  1  reset
- status  input  2  producer status: 00 error, 01 busy, 10 ready
- data  input  4  digit value for index `pos`; values 10..15 mean blank
- pos  input  4  digit index of `data`; values above 7 carry no digit
- an  output  NUM_DIGITS  anode enables, one-hot, polarity per SEG_ACTIVE_LOW
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp  output  1  decimal point, always inactive
- frame_valid  output  1  high once at least one full frame has been committed
- err_shown  output  1  high while the error screen is displayed

Interface (already decided): reset reset, asynchronous, active-high; clock clock.

Behaviour:
- Reset values:
  - `an` all inactive; `seg` all inactive; `dp` inactive.
  - `frame_valid` = 0; `err_shown` = 0.
  - Shadow and display buffers all 4'hF (blank); prescaler and scan index = 0.
- Capture, every clock edge:
  - A beat is a cycle with `status != 2'b10` and `pos <= 7`.
  - On a beat, `shadow[pos] <= data`. Cycles with `status == 2'b10` or `pos > 7` are ignored.
- Commit:
  - A beat with `pos == 7` copies `shadow[6:0]` plus the current `data` into `disp[7:0]` on the same edge (write-through, no loss of digit 7).
  - The same edge sets `frame_valid` to 1; it stays 1 until reset.
  - Latency: the new frame is visible on `an`/`seg` from the next scan slot onward; the current slot is not re-timed.
- Partial frames:
  - Beats without a `pos == 7` beat modify only the shadow; the display is unchanged.
  - Repeated or out-of-order `pos` values overwrite the shadow; the last write wins.
- Error:
  - First cycle with `status == 2'b00` latches `err_shown` = 1, sticky until reset.
  - While `err_shown` = 1, the display shows "Erro" on digits 3..0 (E, r, r, o) with digits 7..4 blank.
  - Capture continues into the shadow but commits are suppressed.
- Blanking:
  - Digit k is blank if `disp[k] > 9`, or if k > 0 and every `disp[j]` for j >= k is 0 or blank.
  - Digit 0 shows 0 when `disp[0] == 0`.
  - Before the first commit (`frame_valid` = 0), all anodes are inactive.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - On the wrap cycle, the scan index advances mod NUM_DIGITS; index 7 wraps to 0.
  - `an` and `seg` are registered and update together on the edge after the index changes, so there is no ghosting.
  - A blank digit drives `seg` all inactive but keeps its anode slot and timing.
- Segment map (a..g):
  - 0-9 standard.
  - E = a,d,e,f,g.
  - r = e,g.
  - o = c,d,e,g.
- Simultaneous events:
  - A `pos == 7` commit on the same edge that `status` first reads 00 is suppressed; the error takes priority.
  - A commit coinciding with a scan advance: the new slot shows the new frame.
- Reset mid-scan or mid-frame: immediate return to reset values; no partial frame survives.

Decomposition:
- Package `calc_disp_pkg`:
  - Status constants ST_ERRO = 2'b00, ST_OCUP = 2'b01, ST_PRONTO = 2'b10.
  - Glyph enum: DIGIT_0..DIGIT_9, GLYPH_E, GLYPH_R, GLYPH_O, GLYPH_BLANK.
  - 7-bit active-high segment constants for each glyph.
- Sub-module `seg7_encode`: combinational glyph to 7-bit segments, with polarity applied by the parent.
- Parent contains: capture/commit logic, error latch, blanking, prescaler, scan counter and output registers.

Test Plan (REFRESH_DIV = 4, SEG_ACTIVE_LOW = 1):
- Reset, then 40 idle cycles → `an` = 8'hFF, `seg` = 7'h7F, `frame_valid` = 0, `err_shown` = 0.
- Beats pos 0..7 = 3,2,1,0,0,0,0,0 (value 123) → `frame_valid` rises on the pos-7 edge. Over one 32-cycle scan:
  - slot 0: `an` = 8'hFE, `seg` shows "3";
  - slots 1 and 2 show "2" and "1";
  - slots 3..7 are blank (`seg` = 7'h7F).
- Frame "123" committed, then beats pos 0..6 of 9s with no pos-7 beat → display still 123. A final pos-7 beat with 9 → display 99999999.
- All-zero frame → only digit 0 lit, showing "0"; `data` = 4'hA on pos 2 → that digit is blank.
- `status` = 00 for 1 cycle, then back to 01 with a full frame → `err_shown` = 1 and stays. Digits 3..0 show E, r, r, o; 7..4 blank; the frame is ignored.
- Assert reset mid-frame (after pos 4) and mid-scan → all outputs at reset values on the next sample; a fresh full frame then displays correctly.

Source files
------------

// File: rtl/calc_display_rx_pkg.sv
// Shared types and constants for the calculator display-stream receiver.
// Holds the status codes, the glyph set and the active-high segment patterns.
package calc_disp_pkg;

    localparam int unsigned STATUS_W = 2;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned POS_W    = 4;
    localparam int unsigned SEG_W    = 7;

    typedef logic [STATUS_W-1:0] status_t;
    typedef logic [DATA_W-1:0]   digit_t;
    typedef logic [POS_W-1:0]    pos_t;
    typedef logic [SEG_W-1:0]    seg_t;

    // One beat of the serialized display stream as seen on the bus.
    typedef struct packed {
        status_t status;
        digit_t  data;
        pos_t    pos;
    } beat_t;

    localparam status_t ST_ERRO   = 2'b00;
    localparam status_t ST_OCUP   = 2'b01;
    localparam status_t ST_PRONTO = 2'b10;

    localparam digit_t DIGIT_BLANK = 4'hF;

    typedef enum logic [3:0] {
        DIGIT_0     = 4'd0,
        DIGIT_1     = 4'd1,
        DIGIT_2     = 4'd2,
        DIGIT_3     = 4'd3,
        DIGIT_4     = 4'd4,
        DIGIT_5     = 4'd5,
        DIGIT_6     = 4'd6,
        DIGIT_7     = 4'd7,
        DIGIT_8     = 4'd8,
        DIGIT_9     = 4'd9,
        GLYPH_E     = 4'd10,
        GLYPH_R     = 4'd11,
        GLYPH_O     = 4'd12,
        GLYPH_BLANK = 4'd13
    } glyph_t;

    // Segment bit order is {g,f,e,d,c,b,a}; 1 = segment lit.
    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_E     = 7'h79;
    localparam seg_t SEG_R     = 7'h50;
    localparam seg_t SEG_O     = 7'h5C;
    localparam seg_t SEG_BLANK = 7'h00;

    // A stored digit that stops leading-zero blanking: a real digit 1..9.
    function automatic logic is_significant(input digit_t d);
        return (d != 4'd0) && (d <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_display_rx_if.sv
// Serialized display stream from the calculator core to the display receiver.
interface calc_display_rx_if;
    import calc_disp_pkg::*;

    status_t status;
    digit_t  data;
    pos_t    pos;

    modport master (output status, data, pos);
    modport slave  (input  status, data, pos);

endinterface

// File: rtl/calc_display_rx_seg7_encode.sv
// Glyph to active-high 7-segment pattern; output polarity is applied by the parent.
module seg7_encode
    import calc_disp_pkg::*;
(
    input  glyph_t glyph,
    output seg_t   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (glyph)
            DIGIT_0:     seg_c = SEG_0;
            DIGIT_1:     seg_c = SEG_1;
            DIGIT_2:     seg_c = SEG_2;
            DIGIT_3:     seg_c = SEG_3;
            DIGIT_4:     seg_c = SEG_4;
            DIGIT_5:     seg_c = SEG_5;
            DIGIT_6:     seg_c = SEG_6;
            DIGIT_7:     seg_c = SEG_7;
            DIGIT_8:     seg_c = SEG_8;
            DIGIT_9:     seg_c = SEG_9;
            GLYPH_E:     seg_c = SEG_E;
            GLYPH_R:     seg_c = SEG_R;
            GLYPH_O:     seg_c = SEG_O;
            GLYPH_BLANK: seg_c = SEG_BLANK;
            default:     seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_display_rx.sv
// Receives the calculator display stream, commits whole frames atomically and
// scans them onto a multiplexed common-anode 7-segment display.
module calc_display_rx
    import calc_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    calc_display_rx_if.slave      bus,
    output logic [NUM_DIGITS-1:0] an,
    output seg_t                  seg,
    output logic                  dp,
    output logic                  frame_valid,
    output logic                  err_shown
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam pos_t                  LAST_POS = POS_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{SEG_ACTIVE_LOW}};
    localparam seg_t                  SEG_OFF  = {SEG_W{SEG_ACTIVE_LOW}};

    beat_t                  in_c;
    logic                   beat_c;
    logic                   commit_c;
    logic [IDX_W-1:0]       wr_idx_c;
    logic                   wrap_c;
    logic                   lit_c;
    logic                   sig_seen_c;
    glyph_t                 glyph_c;
    seg_t                   seg_c;
    logic [NUM_DIGITS-1:0]  an_c;

    digit_t                 shadow [NUM_DIGITS];
    digit_t                 disp   [NUM_DIGITS];
    logic [CNT_W-1:0]       presc;
    logic [IDX_W-1:0]       scan_idx;
    logic                   load;

    assign in_c = {bus.status, bus.data, bus.pos};

    // Beat qualification; an error cycle or a latched error blocks the commit.
    always_comb begin
        beat_c   = (in_c.status != ST_PRONTO) && (in_c.pos <= LAST_POS);
        wr_idx_c = IDX_W'(in_c.pos);
        commit_c = beat_c && (in_c.pos == LAST_POS) &&
                   (in_c.status != ST_ERRO) && !err_shown;
    end

    // Shadow capture and whole-frame commit; the last digit is written through.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                shadow[k] <= DIGIT_BLANK;
                disp[k]   <= DIGIT_BLANK;
            end
        end else begin
            if (beat_c) begin
                shadow[wr_idx_c] <= in_c.data;
            end
            if (commit_c) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    disp[k] <= (k == NUM_DIGITS - 1) ? in_c.data : shadow[k];
                end
            end
        end
    end

    // Sticky status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            err_shown   <= 1'b0;
        end else begin
            if (commit_c) begin
                frame_valid <= 1'b1;
            end
            if (in_c.status == ST_ERRO) begin
                err_shown <= 1'b1;
            end
        end
    end

    assign wrap_c = (presc == CNT_LAST);

    // Prescaler and scan index; load marks the first cycle of each new slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            scan_idx <= '0;
            load     <= 1'b0;
        end else begin
            presc <= wrap_c ? '0 : presc + CNT_W'(1);
            load  <= wrap_c;
            if (wrap_c) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
            end
        end
    end

    // Glyph for the digit currently being scanned, with leading-zero blanking.
    always_comb begin
        glyph_c    = GLYPH_BLANK;
        sig_seen_c = 1'b0;
        if (err_shown) begin
            if (scan_idx == IDX_W'(3)) begin
                glyph_c = GLYPH_E;
            end else if ((scan_idx == IDX_W'(2)) || (scan_idx == IDX_W'(1))) begin
                glyph_c = GLYPH_R;
            end else if (scan_idx == '0) begin
                glyph_c = GLYPH_O;
            end
        end else begin
            for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
                sig_seen_c = sig_seen_c | is_significant(disp[k]);
                if (IDX_W'(k) == scan_idx) begin
                    if ((disp[k] > 4'd9) || ((k != 0) && !sig_seen_c)) begin
                        glyph_c = GLYPH_BLANK;
                    end else begin
                        glyph_c = glyph_t'(disp[k]);
                    end
                end
            end
        end
    end

    seg7_encode u_seg7_encode (
        .glyph (glyph_c),
        .seg_c (seg_c)
    );

    always_comb begin
        an_c  = NUM_DIGITS'(1) << scan_idx;
        lit_c = frame_valid || err_shown;
    end

    // Anodes and segments change together, only at the start of a slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (load) begin
            an  <= (lit_c ? an_c  : '0) ^ AN_OFF;
            seg <= (lit_c ? seg_c : '0) ^ SEG_OFF;
        end
    end

    assign dp = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_calc_display_rx.sv
// Scoreboard bench for calc_display_rx: a frame model pushes expected screens,
// the scan monitor pops and compares them slot by slot.
module tb_calc_display_rx;
    import calc_disp_pkg::*;

    localparam int unsigned RDIV = 4;

    typedef logic [7:0][6:0] frame_t;

    logic       clock;
    logic       reset;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_valid;
    logic       err_shown;

    calc_display_rx_if bus ();

    calc_display_rx #(
        .NUM_DIGITS     (8),
        .REFRESH_DIV    (RDIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_valid (frame_valid),
        .err_shown   (err_shown)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errs   = 0;
    logic [3:0] shadow_m [8];
    logic [3:0] disp_m   [8];
    bit         err_m;
    bit         fv_m;
    frame_t     sb [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Active-low pattern: 0..9 digits, 10 E, 11 r, 12 o, anything else blank.
    function automatic logic [6:0] pat(input int g);
        logic [6:0] p;
        case (g)
            0: p = 7'b0111111;  1: p = 7'b0000110;  2: p = 7'b1011011;
            3: p = 7'b1001111;  4: p = 7'b1100110;  5: p = 7'b1101101;
            6: p = 7'b1111101;  7: p = 7'b0000111;  8: p = 7'b1111111;
            9: p = 7'b1101111;  10: p = 7'b1111001; 11: p = 7'b1010000;
            12: p = 7'b1011100;
            default: p = 7'b0000000;
        endcase
        return ~p;
    endfunction

    function automatic frame_t build_frame();
        frame_t f;
        bit     lead = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            if (err_m) begin
                f[k] = (k == 3) ? pat(10) : (k == 2 || k == 1) ? pat(11) :
                       (k == 0) ? pat(12) : pat(-1);
            end else begin
                if (disp_m[k] >= 4'd1 && disp_m[k] <= 4'd9) lead = 1'b0;
                f[k] = (disp_m[k] > 4'd9 || (k > 0 && lead)) ? pat(-1) : pat(int'(disp_m[k]));
            end
        end
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            shadow_m[k] = 4'hF;
            disp_m[k]   = 4'hF;
        end
        err_m = 1'b0;
        fv_m  = 1'b0;
        sb.delete();
    endtask

    task automatic idle();
        bus.status = ST_PRONTO;
        bus.data   = 4'h0;
        bus.pos    = 4'hF;
    endtask

    // Drive one cycle of the stream and advance the reference model.
    task automatic beat(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        bit commit;
        bus.status = st;
        bus.data   = d;
        bus.pos    = p;
        tick();
        commit = (st != ST_PRONTO) && (p == 4'd7) && (st != ST_ERRO) && !err_m;
        if (st != ST_PRONTO && p <= 4'd7) shadow_m[p] = d;
        if (st == ST_ERRO && !err_m) begin
            err_m = 1'b1;
            sb.push_back(build_frame());
        end
        if (commit) begin
            disp_m = shadow_m;
            fv_m   = 1'b1;
            sb.push_back(build_frame());
        end
        idle();
    endtask

    task automatic send_frame(input logic [7:0][3:0] f, input logic [1:0] st);
        for (int k = 0; k < 8; k++) beat(st, f[k], 4'(k));
    endtask

    task automatic wait_an_change(output bit ok);
        logic [7:0] prev;
        prev = an;
        ok   = 1'b0;
        for (int n = 0; n < 3 * RDIV + 4 && !ok; n++) begin
            tick();
            if (an !== prev) ok = 1'b1;
        end
    endtask

    // Pop one expected screen and compare it over a full scan of 8 slots.
    task automatic scan_check(input string tag);
        frame_t     exp;
        logic [7:0] exp_an;
        bit         ok;
        int         k;
        int         last_k;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb"}, 32'd0, 32'd1);
            return;
        end
        exp    = sb.pop_front();
        last_k = 0;
        for (int s = 0; s < 8; s++) begin
            wait_an_change(ok);
            check_eq({tag, "_slot"}, 32'(ok), 32'd1);
            k = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) k = i;
            if (s == 0) begin
                check_eq({tag, "_an1hot"}, 32'($countones(~an)), 32'd1);
            end else begin
                exp_an = ~(8'b1 << ((last_k + 1) % 8));
                check_eq({tag, "_an"}, 32'(an), 32'(exp_an));
            end
            check_eq({tag, "_seg"}, 32'(seg), 32'(exp[k]));
            last_k = k;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_an"},  32'(an),          32'hFF);
        check_eq({tag, "_seg"}, 32'(seg),         32'h7F);
        check_eq({tag, "_dp"},  32'(dp),          32'd1);
        check_eq({tag, "_fv"},  32'(frame_valid), 32'(fv_m));
        check_eq({tag, "_err"}, 32'(err_shown),   32'(err_m));
    endtask

    initial begin
        logic [31:0] rnd;
        model_reset();
        idle();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (40) tick();
        check_reset_outputs("idle");

        // 123: pos 0..7 = 3,2,1,0,0,0,0,0
        for (int k = 0; k < 7; k++) beat(ST_OCUP, (k < 3) ? 4'(3 - k) : 4'd0, 4'(k));
        check_eq("fv_before_pos7", 32'(frame_valid), 32'd0);
        beat(ST_OCUP, 4'd0, 4'd7);
        check_eq("fv_after_pos7", 32'(frame_valid), 32'd1);
        scan_check("f123");

        // Partial frame of 9s leaves the screen alone until pos 7 arrives.
        for (int k = 0; k < 7; k++) beat(ST_OCUP, 4'd9, 4'(k));
        sb.push_back(build_frame());
        scan_check("partial");
        beat(ST_OCUP, 4'd9, 4'd7);
        scan_check("f99999999");

        send_frame(32'h0000_0000, ST_OCUP);
        scan_check("zeros");

        // Blank code mid-number, ignored cycles, and a rewritten position.
        beat(ST_OCUP, 4'd5, 4'd0);
        beat(ST_OCUP, 4'd0, 4'd1);
        beat(ST_OCUP, 4'hA, 4'd2);
        beat(ST_OCUP, 4'd1, 4'd3);
        beat(ST_PRONTO, 4'd8, 4'd0);
        beat(ST_OCUP, 4'd6, 4'd9);
        beat(ST_OCUP, 4'd7, 4'd3);
        for (int k = 4; k < 8; k++) beat(ST_OCUP, 4'd0, 4'(k));
        scan_check("blank_mid");

        for (int r = 0; r < 3; r++) begin
            rnd = $urandom();
            send_frame(rnd, (r == 1) ? 2'b11 : ST_OCUP);
            scan_check("rnd");
        end

        // Error screen, sticky, and a later full frame is not committed.
        beat(ST_ERRO, 4'd0, 4'hF);
        check_eq("err_rise", 32'(err_shown), 32'd1);
        send_frame(32'h1234_5678, ST_OCUP);
        scan_check("erro");
        check_eq("err_sticky", 32'(err_shown), 32'd1);

        // Reset while the error screen is being scanned.
        reset = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("rst_scan");
        tick();
        reset = 1'b0;

        // Reset after pos 4: the earlier digits must not survive.
        for (int k = 0; k < 5; k++) beat(ST_OCUP, 4'(k + 1), 4'(k));
        reset = 1'b1;
        model_reset();
        #2;
        check_reset_outputs("rst_frame");
        tick();
        reset = 1'b0;
        beat(ST_OCUP, 4'd1, 4'd5);
        beat(ST_OCUP, 4'd2, 4'd6);
        beat(ST_OCUP, 4'd3, 4'd7);
        scan_check("after_rst_tail");
        send_frame(32'h0045_6780, ST_OCUP);
        scan_check("after_rst_full");

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
